// File: rtl/fmul_param.sv
// fmul_param: pipelined floating-point multiplier with configurable exponent and
// fraction widths, run-time rounding mode, exception flags and special values.
//
// Ports
//   iCLOCK, iRESET (async, high), iRESET_SYNC (sync, high)
//   iDATA_REQ / oDATA_BUSY      : operand handshake; accept = iDATA_REQ && !oDATA_BUSY
//   iDATA_A, iDATA_B            : operands {sign, exp, frac}
//   iRMODE                      : 0 RNE, 1 RTZ, 2 toward +inf, 3 toward -inf
//   oDATA_VALID / iDATA_BUSY    : result handshake; consume = oDATA_VALID && !iDATA_BUSY
//   oDATA, oFLAGS               : product and {invalid, overflow, underflow, inexact}
//
// Pipeline: operand register, S1 classify, S2 multiply, S3 round/pack into the
// output register. Result is valid three edges after the accepting edge. Any stall
// freezes the whole pipe.
module fmul_param #(
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 24
) (
  input  logic                  iCLOCK,
  input  logic                  iRESET,
  input  logic                  iRESET_SYNC,
  input  logic                  iDATA_REQ,
  output logic                  oDATA_BUSY,
  input  logic [EXP_W+FRAC_W:0] iDATA_A,
  input  logic [EXP_W+FRAC_W:0] iDATA_B,
  input  logic [1:0]            iRMODE,
  output logic                  oDATA_VALID,
  input  logic                  iDATA_BUSY,
  output logic [EXP_W+FRAC_W:0] oDATA,
  output logic [3:0]            oFLAGS
);
  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int F      = FRAC_W;
  localparam int STAGES = 3;

  localparam logic [1:0] RNE = 2'd0;
  localparam logic [1:0] RTZ = 2'd1;
  localparam logic [1:0] RUP = 2'd2;

  localparam logic signed [EXP_W+1:0] BIAS     = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [EXP_W+1:0] EXP_TOP  = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(F-1){1'b0}}};

  // {zero (incl. flushed denormal), inf, nan, signalling nan}
  function automatic logic [3:0] classify(input logic [W-1:0] x);
    logic expOnes, expZero, fracZero;
    expOnes  = &x[W-2:F];
    expZero  = ~|x[W-2:F];
    fracZero = ~|x[F-1:0];
    classify = {expZero, expOnes & fracZero, expOnes & !fracZero,
                expOnes & !fracZero & !x[F-1]};
  endfunction

  logic [STAGES:0] vldPipe;
  logic            stall, adv;

  assign oDATA_VALID = vldPipe[STAGES];
  assign stall       = oDATA_VALID && iDATA_BUSY;
  assign adv         = !stall;
  assign oDATA_BUSY  = stall;

  // operand register
  logic [W-1:0] s0A, s0B;
  logic [1:0]   s0Rm;

  // S1: classification
  logic             s1Sign;
  logic [EXP_W-1:0] s1ExpA, s1ExpB;
  logic [F:0]       s1SigA, s1SigB;
  logic [3:0]       s1ClsA, s1ClsB;
  logic [1:0]       s1Rm;

  // S2: raw product and special-case resolution
  logic [2*F+1:0]         prod, s2Prod;
  logic signed [EXP_W+1:0] expSum, s2Exp;
  logic                   special, s2Special, s2Sign;
  logic [W-1:0]           specData, s2SpecData;
  logic [3:0]             specFlags, s2SpecFlags;
  logic [1:0]             s2Rm;

  // S3: normalise, round, pack
  logic                   hi, grd, rnd, stk, inexact, up, toInf;
  logic [F-1:0]           mant;
  logic [F:0]             rounded;
  logic signed [EXP_W+1:0] expR;
  logic [W-1:0]           s3Data;
  logic [3:0]             s3Flags;

  always_comb begin
    prod   = {{(F+1){1'b0}}, s1SigA} * {{(F+1){1'b0}}, s1SigB};
    expSum = $signed({2'b00, s1ExpA}) + $signed({2'b00, s1ExpB}) - BIAS;
    special   = 1'b1;
    specData  = '0;
    specFlags = '0;
    if (s1ClsA[1] | s1ClsB[1] | (s1ClsA[2] & s1ClsB[3]) | (s1ClsB[2] & s1ClsA[3])) begin
      specData  = QNAN;
      specFlags = {(s1ClsA[2] & s1ClsB[3]) | (s1ClsB[2] & s1ClsA[3]) | s1ClsA[0] | s1ClsB[0],
                   3'b000};
    end else if (s1ClsA[2] | s1ClsB[2]) begin
      specData = {s1Sign, {EXP_W{1'b1}}, {F{1'b0}}};
    end else if (s1ClsA[3] | s1ClsB[3]) begin
      specData = {s1Sign, {(W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  always_comb begin
    // product of two [1,2) significands lies in [1,4); hi selects the 1-bit shift
    hi = s2Prod[2*F+1];
    if (hi) begin
      mant = s2Prod[2*F:F+1];
      grd  = s2Prod[F];
      rnd  = s2Prod[F-1];
      stk  = |s2Prod[F-2:0];
    end else begin
      mant = s2Prod[2*F-1:F];
      grd  = s2Prod[F-1];
      rnd  = s2Prod[F-2];
      stk  = |s2Prod[F-3:0];
    end
    inexact = grd | rnd | stk;
    up = 1'b0;
    case (s2Rm)
      RNE:     up = grd & (rnd | stk | mant[0]);
      RTZ:     up = 1'b0;
      RUP:     up = inexact & !s2Sign;
      default: up = inexact & s2Sign;
    endcase
    // rounding carry out of the fraction leaves frac = 0 and bumps the exponent
    rounded = {1'b0, mant} + {{F{1'b0}}, up};
    expR    = s2Exp + $signed({{(EXP_W+1){1'b0}}, hi})
                    + $signed({{(EXP_W+1){1'b0}}, rounded[F]});
    toInf   = (s2Rm == RNE) || (s2Rm == RUP && !s2Sign) || (s2Rm == 2'd3 && s2Sign);
    s3Data  = {s2Sign, expR[EXP_W-1:0], rounded[F-1:0]};
    s3Flags = {3'b000, inexact};
    if (s2Special) begin
      s3Data  = s2SpecData;
      s3Flags = s2SpecFlags;
    end else if (expR >= EXP_TOP) begin
      s3Flags = 4'b0101;
      s3Data  = toInf ? {s2Sign, {EXP_W{1'b1}}, {F{1'b0}}}
                      : {s2Sign, {(EXP_W-1){1'b1}}, 1'b0, {F{1'b1}}};
    end else if (expR <= EXP_ZERO) begin
      s3Flags = 4'b0011;
      s3Data  = {s2Sign, {(W-1){1'b0}}};
    end
  end

  // datapath registers carry no reset: only valids and outputs are architectural
  always_ff @(posedge iCLOCK) begin
    if (adv) begin
      s0A    <= iDATA_A;
      s0B    <= iDATA_B;
      s0Rm   <= iRMODE;
      s1Sign <= s0A[W-1] ^ s0B[W-1];
      s1ExpA <= s0A[W-2:F];
      s1ExpB <= s0B[W-2:F];
      s1SigA <= {1'b1, s0A[F-1:0]};
      s1SigB <= {1'b1, s0B[F-1:0]};
      s1ClsA <= classify(s0A);
      s1ClsB <= classify(s0B);
      s1Rm   <= s0Rm;
      s2Prod      <= prod;
      s2Exp       <= expSum;
      s2Sign      <= s1Sign;
      s2Rm        <= s1Rm;
      s2Special   <= special;
      s2SpecData  <= specData;
      s2SpecFlags <= specFlags;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      vldPipe <= '0;
      oDATA   <= '0;
      oFLAGS  <= '0;
    end else if (iRESET_SYNC) begin
      vldPipe <= '0;
      oDATA   <= '0;
      oFLAGS  <= '0;
    end else if (adv) begin
      vldPipe <= {vldPipe[STAGES-1:0], iDATA_REQ};
      if (vldPipe[STAGES-1]) begin
        oDATA  <= s3Data;
        oFLAGS <= s3Flags;
      end
    end
  end
endmodule
